// File: rtl/peri_arb_pkg.sv
// peri_arb_pkg: master-id encoding, pipe request/response bundles and the ID FIFO depth default
package peri_arb_pkg;
    localparam int OUTSTANDING_DEF = 4;
    typedef enum logic {M0 = 1'b0, M1 = 1'b1} mid_e;
    typedef struct packed {
        logic        r;
        logic        w;
        logic [31:0] a;
        logic [31:0] wd;
    } req_t;
    typedef struct packed {
        logic        hold;
        logic        rv;
        logic [31:0] rd;
    } res_t;
    function automatic logic req_valid(req_t q);
        return q.r | q.w;
    endfunction
endpackage

// File: rtl/peri_arb_if.sv
// peri_arb_if: one peripheral pipe (request out of a master, response back into it)
interface peri_arb_if;
    import peri_arb_pkg::*;
    req_t req;
    res_t res;
    modport master (output req, input res);
    modport slave  (input req, output res);
endinterface

// File: rtl/peri_arb_idfifo.sv
// peri_arb_idfifo: 1-bit-wide sync FIFO holding the master id of each read in flight
module peri_arb_idfifo
    import peri_arb_pkg::*;
#(
    parameter int DEPTH = OUTSTANDING_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  logic pop_i,
    input  logic din_i,
    output logic dout_o,
    output logic full_o,
    output logic empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0]    wp_q, rp_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;
    // a pop frees the head slot, so a push is legal in the same cycle even when full
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign dout_o  = mem_q[rp_q];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wp_q] <= din_i;
                wp_q        <= wp_q + 1'b1;
            end
            if (do_pop) rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/peri_arb.sv
// peri_arb: round-robin two-master arbiter for the peripheral pipe with in-order read steering.
// Define PERI_ARB_STATS_EN to add per-master accept counters (m0_cnt_o/m1_cnt_o).
module peri_arb
    import peri_arb_pkg::*;
#(
    parameter int OUTSTANDING = OUTSTANDING_DEF
`ifdef PERI_ARB_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
    input  logic         clk,
    input  logic         rst,
    peri_arb_if.slave    m0_io,
    peri_arb_if.slave    m1_io,
    peri_arb_if.master   peri_io
`ifdef PERI_ARB_STATS_EN
  , output logic [CNT_W-1:0] m0_cnt_o,
    output logic [CNT_W-1:0] m1_cnt_o
`endif
);
    logic v0, v1, e0, e1, gnt_v, acc, push, pop, full, empty, head_bit;
    logic held_q, held_d;
    mid_e gnt_id, head, last_q, last_d, held_id_q, held_id_d;
    req_t win_req;
    peri_arb_idfifo #(.DEPTH(OUTSTANDING)) u_fifo (
        .clk(clk), .rst(rst), .push_i(push), .pop_i(pop), .din_i(gnt_id),
        .dout_o(head_bit), .full_o(full), .empty_o(empty)
    );
    assign head = mid_e'(head_bit);
    always_comb begin
        v0 = req_valid(m0_io.req);
        v1 = req_valid(m1_io.req);
        pop = peri_io.res.rv & ~empty;
        // a read may only be forwarded while the ID FIFO has (or is freeing) a slot
        e0 = v0 & ~(m0_io.req.r & full & ~pop);
        e1 = v1 & ~(m1_io.req.r & full & ~pop);
        gnt_v = e0 | e1;
        gnt_id = (held_q && (held_id_q == M0 ? e0 : e1)) ? held_id_q :
                 (e0 && e1) ? ((last_q == M0) ? M1 : M0) :
                 e0 ? M0 : M1;
        win_req = (gnt_id == M1) ? m1_io.req : m0_io.req;
        peri_io.req = gnt_v ? win_req : '0;
        acc = gnt_v & ~peri_io.res.hold;
        push = acc & win_req.r;
        held_d = gnt_v & peri_io.res.hold;
        held_id_d = gnt_id;
        last_d = acc ? gnt_id : last_q;
        m0_io.res.hold = v0 & (~gnt_v | gnt_id != M0 | peri_io.res.hold);
        m1_io.res.hold = v1 & (~gnt_v | gnt_id != M1 | peri_io.res.hold);
        m0_io.res.rv = pop & head == M0;
        m1_io.res.rv = pop & head == M1;
        m0_io.res.rd = m0_io.res.rv ? peri_io.res.rd : '0;
        m1_io.res.rd = m1_io.res.rv ? peri_io.res.rd : '0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q    <= M1;
            held_q    <= 1'b0;
            held_id_q <= M0;
        end else begin
            last_q    <= last_d;
            held_q    <= held_d;
            held_id_q <= held_id_d;
        end
    end
`ifdef PERI_ARB_STATS_EN
    logic [CNT_W-1:0] m0_cnt_q, m1_cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m0_cnt_q <= '0;
            m1_cnt_q <= '0;
        end else if (acc) begin
            if (gnt_id == M0) m0_cnt_q <= m0_cnt_q + 1'b1;
            else m1_cnt_q <= m1_cnt_q + 1'b1;
        end
    end
    assign m0_cnt_o = m0_cnt_q;
    assign m1_cnt_o = m1_cnt_q;
`endif
endmodule

// File: tb/tb_peri_arb.sv
// tb_peri_arb: scenario tasks for peri_arb; read returns are checked against a queue of expected masters
module tb_peri_arb;
    import peri_arb_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    peri_arb_if m0 ();
    peri_arb_if m1 ();
    peri_arb_if per ();
`ifdef PERI_ARB_STATS_EN
    logic [15:0] m0_cnt, m1_cnt;
`endif
    peri_arb dut (
        .clk(clk), .rst(rst), .m0_io(m0), .m1_io(m1), .peri_io(per)
`ifdef PERI_ARB_STATS_EN
      , .m0_cnt_o(m0_cnt), .m1_cnt_o(m1_cnt)
`endif
    );
    int errors = 0;
    int checks = 0;
    mid_e exp_q[$];
    localparam req_t IDLE = '0;
    localparam res_t OK   = '0;
    localparam res_t HOLD = '{hold: 1'b1, rv: 1'b0, rd: 32'h0};

    function automatic req_t rd_req(input logic [31:0] a);
        return '{r: 1'b1, w: 1'b0, a: a, wd: 32'h0};
    endfunction
    function automatic req_t wr_req(input logic [31:0] a, input logic [31:0] d);
        return '{r: 1'b0, w: 1'b1, a: a, wd: d};
    endfunction

    // inputs change on the falling edge; outputs are sampled 2 time units later
    task automatic drive(input req_t a, input req_t b, input res_t r);
        @(negedge clk);
        m0.req = a;
        m1.req = b;
        per.res = r;
        #2;
    endtask

    task automatic ret(input req_t a, input req_t b, input logic [31:0] d);
        mid_e m;
        logic [31:0] got, oth;
        logic gv;
        drive(a, b, '{hold: 1'b0, rv: 1'b1, rd: d});
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: return %h with no read expected", d);
        end else begin
            m = exp_q.pop_front();
            got = (m == M0) ? m0.res.rd : m1.res.rd;
            oth = (m == M0) ? m1.res.rd : m0.res.rd;
            gv = (m == M0) ? m0.res.rv : m1.res.rv;
            if (got !== d || gv !== 1'b1 || oth !== 32'h0) begin
                errors++;
                $display("FAIL steer_m%0d: got rd=%h rv=%b other=%h, want rd=%h rv=1 other=0", m, got, gv, oth, d);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(IDLE, IDLE, OK);
        checks++;
        if (per.req !== IDLE) begin errors++; $display("FAIL reset_peri_req: got %h want 0", per.req); end
        checks++;
        if (m0.res !== OK) begin errors++; $display("FAIL reset_m0_res: got %h want 0", m0.res); end
        checks++;
        if (m1.res !== OK) begin errors++; $display("FAIL reset_m1_res: got %h want 0", m1.res); end
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        req_t a, b, w;
        int n0 = 0;
        int n1 = 0;
        for (int i = 0; i < 8; i++) begin
            a = wr_req(32'hFF00_0100 + i, i);
            b = wr_req(32'hFF00_0200 + i, 100 + i);
            drive(a, b, OK);
            w = (i % 2 == 0) ? a : b;
            checks++;
            if (per.req !== w) begin errors++; $display("FAIL rr_grant_%0d: got %h want %h", i, per.req, w); end
            checks++;
            if (m0.res.hold !== (i % 2 == 1) || m1.res.hold !== (i % 2 == 0)) begin
                errors++;
                $display("FAIL rr_hold_%0d: got m0=%b m1=%b want m0=%b m1=%b", i, m0.res.hold, m1.res.hold, i % 2 == 1, i % 2 == 0);
            end
            if (per.req === a) n0++;
            if (per.req === b) n1++;
        end
        checks++;
        if (n0 != 4 || n1 != 4) begin errors++; $display("FAIL rr_counts: got m0=%0d m1=%0d want 4/4", n0, n1); end
    endtask

    task automatic test_single_read();
        req_t a;
        a = rd_req(32'hFF00_0000);
        drive(a, IDLE, OK);
        checks++;
        if (per.req !== a || m0.res.hold !== 1'b0) begin
            errors++;
            $display("FAIL single_fwd: got req=%h hold=%b want req=%h hold=0", per.req, m0.res.hold, a);
        end
        exp_q.push_back(M0);
        drive(IDLE, IDLE, OK);
        checks++;
        if (per.req !== IDLE) begin errors++; $display("FAIL single_idle: got %h want 0", per.req); end
        ret(IDLE, IDLE, 32'hDEAD_BEEF);
        checks++;
        if (m1.res.rv !== 1'b0) begin errors++; $display("FAIL single_m1_rv: got %b want 0", m1.res.rv); end
    endtask

    task automatic test_hold();
        req_t a, b, p;
        p = wr_req(32'hFF00_0300, 1);
        drive(IDLE, p, OK);
        checks++;
        if (per.req !== p) begin errors++; $display("FAIL hold_pre: got %h want %h", per.req, p); end
        a = wr_req(32'hFF00_0400, 5);
        b = rd_req(32'hFF00_0304);
        drive(IDLE, b, HOLD);
        checks++;
        if (per.req !== b || m1.res.hold !== 1'b1) begin
            errors++;
            $display("FAIL hold_first: got req=%h hold=%b want req=%h hold=1", per.req, m1.res.hold, b);
        end
        for (int i = 0; i < 2; i++) begin
            drive(a, b, HOLD);
            checks++;
            if (per.req !== b || m0.res.hold !== 1'b1 || m1.res.hold !== 1'b1) begin
                errors++;
                $display("FAIL hold_stay_%0d: got req=%h h0=%b h1=%b want req=%h h0=1 h1=1", i, per.req, m0.res.hold, m1.res.hold, b);
            end
        end
        drive(a, b, OK);
        checks++;
        if (per.req !== b || m1.res.hold !== 1'b0 || m0.res.hold !== 1'b1) begin
            errors++;
            $display("FAIL hold_accept: got req=%h h0=%b h1=%b want req=%h h0=1 h1=0", per.req, m0.res.hold, m1.res.hold, b);
        end
        exp_q.push_back(M1);
        drive(a, IDLE, OK);
        checks++;
        if (per.req !== a || m0.res.hold !== 1'b0) begin
            errors++;
            $display("FAIL hold_next_m0: got req=%h hold=%b want req=%h hold=0", per.req, m0.res.hold, a);
        end
        ret(IDLE, IDLE, 32'h5A5A_0001);
    endtask

    task automatic test_full();
        req_t c, w;
        for (int i = 0; i < 4; i++) begin
            drive(rd_req(32'hFF00_1000 + 4 * i), IDLE, OK);
            exp_q.push_back(M0);
            checks++;
            if (m0.res.hold !== 1'b0) begin errors++; $display("FAIL full_fill_%0d: got hold=%b want 0", i, m0.res.hold); end
        end
        c = rd_req(32'hFF00_1010);
        drive(c, IDLE, OK);
        checks++;
        if (m0.res.hold !== 1'b1 || per.req !== IDLE) begin
            errors++;
            $display("FAIL full_block: got hold=%b req=%h want hold=1 req=0", m0.res.hold, per.req);
        end
        w = wr_req(32'hFF00_2000, 32'h77);
        drive(c, w, OK);
        checks++;
        if (per.req !== w || m1.res.hold !== 1'b0 || m0.res.hold !== 1'b1) begin
            errors++;
            $display("FAIL full_write: got req=%h h0=%b h1=%b want req=%h h0=1 h1=0", per.req, m0.res.hold, m1.res.hold, w);
        end
        ret(c, IDLE, 32'h0000_00A0);
        checks++;
        if (per.req !== c || m0.res.hold !== 1'b0) begin
            errors++;
            $display("FAIL full_swap: got req=%h hold=%b want req=%h hold=0", per.req, m0.res.hold, c);
        end
        exp_q.push_back(M0);
        drive(c, IDLE, OK);
        checks++;
        if (m0.res.hold !== 1'b1) begin errors++; $display("FAIL full_still: got hold=%b want 1", m0.res.hold); end
        for (int i = 0; i < 4; i++) ret(IDLE, IDLE, 32'h0000_00B0 + i);
    endtask

    task automatic test_interleave();
        mid_e s[4] = '{M0, M1, M1, M0};
        logic [31:0] d[4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        req_t q;
        for (int i = 0; i < 4; i++) begin
            q = rd_req(32'hFF00_3000 + 4 * i);
            if (s[i] == M0) drive(q, IDLE, OK);
            else drive(IDLE, q, OK);
            exp_q.push_back(s[i]);
            checks++;
            if (per.req !== q) begin errors++; $display("FAIL il_fwd_%0d: got %h want %h", i, per.req, q); end
        end
        for (int i = 0; i < 4; i++) ret(IDLE, IDLE, d[i]);
    endtask

    task automatic test_rst();
        req_t a, b;
        drive(IDLE, rd_req(32'hFF00_4000), OK);
        drive(rd_req(32'hFF00_4004), IDLE, OK);
        @(negedge clk);
        rst = 1'b1;
        m0.req = IDLE;
        m1.req = IDLE;
        per.res = OK;
        #2;
        checks++;
        if (per.req !== IDLE || m0.res !== OK || m1.res !== OK) begin
            errors++;
            $display("FAIL rst_outputs: got req=%h r0=%h r1=%h want all 0", per.req, m0.res, m1.res);
        end
`ifdef PERI_ARB_STATS_EN
        checks++;
        if (m0_cnt !== 16'd0 || m1_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rst_cnt: got %0d/%0d want 0/0", m0_cnt, m1_cnt);
        end
`endif
        rst = 1'b0;
        drive(IDLE, IDLE, '{hold: 1'b0, rv: 1'b1, rd: 32'hCC});
        checks++;
        if (m0.res.rv !== 1'b0 || m1.res.rv !== 1'b0) begin
            errors++;
            $display("FAIL rst_flushed: got rv0=%b rv1=%b want 0/0", m0.res.rv, m1.res.rv);
        end
        a = wr_req(32'hFF00_5000, 1);
        b = wr_req(32'hFF00_5004, 2);
        drive(a, b, OK);
        checks++;
        if (per.req !== a) begin errors++; $display("FAIL rst_tie: got %h want %h", per.req, a); end
        drive(IDLE, IDLE, OK);
`ifdef PERI_ARB_STATS_EN
        checks++;
        if (m0_cnt !== 16'd1 || m1_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rst_cnt_after: got %0d/%0d want 1/0", m0_cnt, m1_cnt);
        end
`endif
    endtask

    initial begin
        m0.req = IDLE;
        m1.req = IDLE;
        per.res = OK;
        test_reset();
        test_round_robin();
        test_single_read();
        test_hold();
        test_full();
        test_interleave();
        test_rst();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left: got %0d pending want 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
